// File: rtl/ctrl_pkg.sv
// Shared opcode encodings, control-word bit positions and the stage record
// carried through the EX, MEM and WB control registers.
package ctrl_pkg;

   localparam int OP_W  = 7;
   localparam int CW_W  = 8;
   localparam int REG_W = 5;

   localparam logic [OP_W-1:0] OP_NOP  = 7'b0000000;
   localparam logic [OP_W-1:0] OP_ADDI = 7'b0010011;
   localparam logic [OP_W-1:0] OP_ALU  = 7'b0110011;
   localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
   localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
   localparam logic [OP_W-1:0] OP_FPU  = 7'b1010011;

   localparam int CW_ALUSRC   = 7;
   localparam int CW_MEMTOREG = 6;
   localparam int CW_REGWRITE = 5;
   localparam int CW_MEMREAD  = 4;
   localparam int CW_MEMWRITE = 3;
   localparam int CW_BRANCH   = 2;
   localparam int CW_ALUOP_HI = 1;
   localparam int CW_ALUOP_LO = 0;

   typedef struct packed {
      logic             valid;
      logic [CW_W-1:0]  cw;
      logic [REG_W-1:0] rd;
      logic             is_fpu;
   } stage_t;

   function automatic logic [CW_W-1:0] cw_encode(input logic [OP_W-1:0] opcode);
      logic [CW_W-1:0] cw;
      case (opcode)
         OP_ADDI: cw = 8'b10100000;
         OP_ALU:  cw = 8'b00100010;
         OP_LW:   cw = 8'b11110000;
         OP_SW:   cw = 8'b10001000;
         OP_BEQ:  cw = 8'b00000101;
         OP_FPU:  cw = 8'b00100011;
         default: cw = '0;
      endcase
      return cw;
   endfunction

endpackage

// File: rtl/cw_decode.sv
// Purpose: opcode -> control word, illegal flag, rs2 usage and FPU class.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode, the caller decides what to do with it.
module cw_decode
   import ctrl_pkg::*;
(
   input  logic [OP_W-1:0] opcode,
   output logic [CW_W-1:0] cw,
   output logic            illegal,
   output logic            uses_rs2,
   output logic            is_fpu
);

   always_comb begin
      cw       = cw_encode(opcode);
      illegal  = 1'b0;
      uses_rs2 = 1'b0;
      is_fpu   = 1'b0;
      case (opcode)
         OP_NOP, OP_ADDI, OP_LW: begin
         end
         OP_ALU, OP_SW, OP_BEQ: uses_rs2 = 1'b1;
         OP_FPU: begin
            uses_rs2 = 1'b1;
            is_fpu   = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: decode ID opcode and carry controls through EX/MEM/WB with hazard control.
// Latency: ID at t shows at EX t+1, MEM t+2, WB t+3 when nothing stalls.
// Backpressure: ext_stall freezes everything; FPU hold and load-use stall ID via stall_id.
module pipe_ctrl
   import ctrl_pkg::*;
#(
   parameter int REGW    = REG_W,
   parameter int FPU_LAT = 4,
   parameter int OPW     = OP_W
)(
   input  logic            clk,
   input  logic            rstn,
   input  logic            valid_id,
   input  logic [OPW-1:0]  opcode_id,
   input  logic [REGW-1:0] rs1_id,
   input  logic [REGW-1:0] rs2_id,
   input  logic [REGW-1:0] rd_id,
   input  logic            branch_taken_ex,
   input  logic            ext_stall,
   output logic            stall_id,
   output logic            illegal_id,
   output logic            alusrc_ex,
   output logic            branch_ex,
   output logic [1:0]      alu_op_ex,
   output logic [REGW-1:0] rd_ex,
   output logic            memread_mem,
   output logic            memwrite_mem,
   output logic            memtoreg_wb,
   output logic            regwrite_wb,
   output logic [REGW-1:0] rd_wb,
   output logic            fpu_busy
);

   localparam int CNT_W = $clog2(FPU_LAT + 1);

   stage_t           id_rec, ex_q, mem_q, wb_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CW_W-1:0]  dec_cw;
   logic             dec_illegal, dec_uses_rs2, dec_is_fpu;
   logic             load_use, ex_hold;
   logic             unused_wb;

   cw_decode u_decode (
      .opcode   (opcode_id),
      .cw       (dec_cw),
      .illegal  (dec_illegal),
      .uses_rs2 (dec_uses_rs2),
      .is_fpu   (dec_is_fpu)
   );

   // Empty or illegal ID slots become fully zeroed bubbles.
   always_comb begin
      id_rec = '0;
      if (valid_id && !dec_illegal) begin
         id_rec.valid  = 1'b1;
         id_rec.cw     = dec_cw;
         id_rec.rd     = rd_id;
         id_rec.is_fpu = dec_is_fpu;
      end
   end

   assign ex_hold  = ex_q.valid & ex_q.is_fpu & (int'(cnt_q) < FPU_LAT - 1);
   assign load_use = valid_id & ex_q.valid & ex_q.cw[CW_MEMREAD] & (ex_q.rd != '0)
                   & ((ex_q.rd == rs1_id) | (dec_uses_rs2 & (ex_q.rd == rs2_id)));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else if (!ext_stall) begin
         wb_q <= mem_q;
         if (branch_taken_ex) begin
            mem_q <= ex_q;
            ex_q  <= '0;
            cnt_q <= '0;
         end else if (ex_hold) begin
            mem_q <= '0;
            cnt_q <= cnt_q + 1'b1;
         end else if (load_use) begin
            mem_q <= ex_q;
            ex_q  <= '0;
            cnt_q <= '0;
         end else begin
            mem_q <= ex_q;
            ex_q  <= id_rec;
            cnt_q <= '0;
         end
      end
   end

   // Combinational outputs are gated so the whole port reads zero in reset.
   assign stall_id   = rstn & (ext_stall | (~branch_taken_ex & (ex_hold | load_use)));
   assign illegal_id = rstn & valid_id & dec_illegal;
   assign fpu_busy   = ex_hold;

   assign alusrc_ex    = ex_q.valid & ex_q.cw[CW_ALUSRC];
   assign branch_ex    = ex_q.valid & ex_q.cw[CW_BRANCH];
   assign alu_op_ex    = ex_q.cw[CW_ALUOP_HI:CW_ALUOP_LO] & {2{ex_q.valid}};
   assign rd_ex        = ex_q.rd & {REGW{ex_q.valid}};
   assign memread_mem  = mem_q.valid & mem_q.cw[CW_MEMREAD];
   assign memwrite_mem = mem_q.valid & mem_q.cw[CW_MEMWRITE];
   assign memtoreg_wb  = wb_q.valid & wb_q.cw[CW_MEMTOREG];
   assign regwrite_wb  = wb_q.valid & wb_q.cw[CW_REGWRITE];
   assign rd_wb        = wb_q.rd & {REGW{wb_q.valid}};

   assign unused_wb = ^{wb_q.cw[CW_ALUSRC], wb_q.cw[CW_MEMREAD:CW_ALUOP_LO], wb_q.is_fpu};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, FPU/reset corner sequences and
// random stimulus against a slot-level reference model, on FPU_LAT=4 and FPU_LAT=1.
module tb_pipe_ctrl;

   localparam logic [6:0] T_NOP  = 7'b0000000;
   localparam logic [6:0] T_ADDI = 7'b0010011;
   localparam logic [6:0] T_ALU  = 7'b0110011;
   localparam logic [6:0] T_LW   = 7'b0000011;
   localparam logic [6:0] T_SW   = 7'b0100011;
   localparam logic [6:0] T_BEQ  = 7'b1100011;
   localparam logic [6:0] T_FPU  = 7'b1010011;
   localparam logic [6:0] T_BAD  = 7'b1111111;

   logic       clk, rstn, valid_id, branch_taken_ex, ext_stall;
   logic [6:0] opcode_id;
   logic [4:0] rs1_id, rs2_id, rd_id;
   // [20] stall [19] illegal [18] alusrc [17] branch [16:15] alu_op [14:10] rd_ex
   // [9] memread [8] memwrite [7] memtoreg [6] regwrite [5:1] rd_wb [0] fpu_busy
   wire [20:0] out0, out1;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_ctrl #(.REGW(5), .FPU_LAT(4), .OPW(7)) dut0 (
      .clk(clk), .rstn(rstn), .valid_id(valid_id), .opcode_id(opcode_id),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
      .branch_taken_ex(branch_taken_ex), .ext_stall(ext_stall),
      .stall_id(out0[20]), .illegal_id(out0[19]), .alusrc_ex(out0[18]),
      .branch_ex(out0[17]), .alu_op_ex(out0[16:15]), .rd_ex(out0[14:10]),
      .memread_mem(out0[9]), .memwrite_mem(out0[8]), .memtoreg_wb(out0[7]),
      .regwrite_wb(out0[6]), .rd_wb(out0[5:1]), .fpu_busy(out0[0])
   );

   pipe_ctrl #(.REGW(5), .FPU_LAT(1), .OPW(7)) dut1 (
      .clk(clk), .rstn(rstn), .valid_id(valid_id), .opcode_id(opcode_id),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
      .branch_taken_ex(branch_taken_ex), .ext_stall(ext_stall),
      .stall_id(out1[20]), .illegal_id(out1[19]), .alusrc_ex(out1[18]),
      .branch_ex(out1[17]), .alu_op_ex(out1[16:15]), .rd_ex(out1[14:10]),
      .memread_mem(out1[9]), .memwrite_mem(out1[8]), .memtoreg_wb(out1[7]),
      .regwrite_wb(out1[6]), .rd_wb(out1[5:1]), .fpu_busy(out1[0])
   );

   always #5 clk = ~clk;

   // ---------------- reference model: instruction slots ----------------
   typedef struct { bit v; bit [7:0] cw; bit [4:0] rd; bit fpu; } rec_t;

   bit [6:0] ref_op [7] = '{T_NOP, T_ADDI, T_ALU, T_LW, T_SW, T_BEQ, T_FPU};
   bit [7:0] ref_cw [7] = '{8'b00000000, 8'b10100000, 8'b00100010, 8'b11110000,
                            8'b10001000, 8'b00000101, 8'b00100011};
   int   lat [2] = '{4, 1};
   rec_t m_ex [2];
   rec_t m_mem [2];
   rec_t m_wb [2];
   int   m_rem [2];

   function automatic rec_t bubble();
      rec_t r;
      r.v = 0; r.cw = 0; r.rd = 0; r.fpu = 0;
      return r;
   endfunction

   function automatic bit lookup(input bit [6:0] op, output bit [7:0] cw);
      bit found = 0;
      cw = 0;
      for (int i = 0; i < 7; i++)
         if (ref_op[i] == op) begin
            cw = ref_cw[i];
            found = 1;
         end
      return found;
   endfunction

   function automatic bit m_hold(input int k);
      return m_ex[k].v && m_ex[k].fpu && m_rem[k] > 0;
   endfunction

   function automatic bit m_lu(input int k);
      bit u2 = (opcode_id == T_ALU) || (opcode_id == T_SW) || (opcode_id == T_BEQ) || (opcode_id == T_FPU);
      return valid_id && m_ex[k].v && m_ex[k].cw[4] && m_ex[k].rd != 0 &&
             (m_ex[k].rd == rs1_id || (u2 && m_ex[k].rd == rs2_id));
   endfunction

   function automatic logic [20:0] model_out(input int k);
      bit [7:0] c;
      bit legal = lookup(opcode_id, c);
      bit stall = ext_stall || (!branch_taken_ex && (m_hold(k) || m_lu(k)));
      return {stall, valid_id && !legal, m_ex[k].cw[7], m_ex[k].cw[2], m_ex[k].cw[1:0], m_ex[k].rd,
              m_mem[k].cw[4], m_mem[k].cw[3], m_wb[k].cw[6], m_wb[k].cw[5], m_wb[k].rd, m_hold(k)};
   endfunction

   task automatic model_reset(input int k);
      m_ex[k] = bubble(); m_mem[k] = bubble(); m_wb[k] = bubble(); m_rem[k] = 0;
   endtask

   task automatic model_adv(input int k);
      bit [7:0] c;
      bit   legal = lookup(opcode_id, c);
      rec_t id    = bubble();
      bit   hold  = m_hold(k);
      bit   lu    = m_lu(k);
      if (valid_id && legal) begin
         id.v = 1; id.cw = c; id.rd = rd_id; id.fpu = (opcode_id == T_FPU);
      end
      if (ext_stall) begin
      end else if (branch_taken_ex) begin
         m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = bubble();
      end else if (hold) begin
         m_wb[k] = m_mem[k]; m_mem[k] = bubble(); m_rem[k]--;
      end else if (lu) begin
         m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = bubble();
      end else begin
         m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = id; m_rem[k] = lat[k] - 1;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %06h expected %06h", name, act, exp);
      end
   endtask

   task automatic step(input bit v, input bit [6:0] op, input bit [4:0] r1, input bit [4:0] r2,
                       input bit [4:0] rd, input bit b, input bit e, input string tag);
      @(negedge clk);
      valid_id = v; opcode_id = op; rs1_id = r1; rs2_id = r2; rd_id = rd;
      branch_taken_ex = b; ext_stall = e;
      #1;
      chk({tag, "/lat4"}, out0, model_out(0));
      chk({tag, "/lat1"}, out1, model_out(1));
      model_adv(0);
      model_adv(1);
   endtask

   function automatic logic [20:0] mk(bit s, bit il, bit as, bit br, bit [1:0] ao, bit [4:0] re,
                                      bit mr, bit mw, bit mt, bit rw, bit [4:0] rr, bit bz);
      return {s, il, as, br, ao, re, mr, mw, mt, rw, rr, bz};
   endfunction

   typedef struct { bit v; bit [6:0] op; bit [4:0] r1, r2, rd; bit br, ext; logic [20:0] exp; } vec_t;
   vec_t vt [15];

   initial begin
      int busy0, busy1;
      clk = 0; rstn = 0; valid_id = 1; opcode_id = T_BAD;
      rs1_id = 0; rs2_id = 0; rd_id = 0; branch_taken_ex = 0; ext_stall = 1;

      //          v  op      r1 r2 rd br ext     st il as br ao  rde mr mw mt rw rdw bz
      vt[0]  = '{1, T_ADDI, 0, 0, 3, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      vt[1]  = '{1, T_LW,   1, 0, 5, 0, 0, mk(0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0)};
      vt[2]  = '{1, T_ALU,  5, 1, 6, 0, 0, mk(1, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0)};
      vt[3]  = '{1, T_ALU,  5, 1, 6, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 0)};
      vt[4]  = '{1, T_LW,   2, 0, 0, 0, 0, mk(0, 0, 0, 0, 2, 6, 0, 0, 1, 1, 5, 0)};
      vt[5]  = '{1, T_ALU,  0, 0, 7, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      vt[6]  = '{1, T_BAD,  0, 0, 9, 0, 0, mk(0, 1, 0, 0, 2, 7, 1, 0, 0, 1, 6, 0)};
      vt[7]  = '{1, T_BEQ,  1, 2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)};
      vt[8]  = '{1, T_ALU,  5, 1, 8, 1, 0, mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 7, 0)};
      vt[9]  = '{1, T_SW,   1, 2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      vt[10] = '{1, T_NOP,  0, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      vt[11] = '{0, T_BAD,  0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
      vt[12] = '{1, T_LW,   1, 0, 4, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      vt[13] = '{1, T_ALU,  4, 1, 2, 1, 0, mk(0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0)};
      vt[14] = '{0, T_NOP,  0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)};

      model_reset(0);
      model_reset(1);
      #3;
      chk("reset/lat4", out0, '0);
      chk("reset/lat1", out1, '0);
      @(negedge clk);
      rstn = 1; valid_id = 0; ext_stall = 0;

      for (int i = 0; i < 15; i++) begin
         step(vt[i].v, vt[i].op, vt[i].r1, vt[i].r2, vt[i].rd, vt[i].br, vt[i].ext, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_table", i), out0, vt[i].exp);
      end

      // FPU op followed by a waiting addi, with a two-cycle freeze inside the hold.
      busy0 = 0;
      busy1 = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 0)
            step(1, T_FPU, 1, 2, 10, 0, 0, "fpu");
         else if (i < 7)
            step(1, T_ADDI, 0, 0, 11, 0, (i == 2 || i == 3), "fpu");
         else
            step(0, T_NOP, 0, 0, 0, 0, 0, "fpu");
         busy0 += int'(out0[0]);
         busy1 += int'(out1[0]);
         if (i == 7)
            chk("fpu_then_addi_ex", {15'd0, out0[18], out0[14:10]}, {15'd0, 1'b1, 5'd11});
      end
      chk("fpu_busy_cycles_lat4", 21'(busy0), 21'd5);
      chk("fpu_busy_cycles_lat1", 21'(busy1), 21'd0);

      // Asynchronous reset while the FPU op is holding EX.
      step(0, T_NOP, 0, 0, 0, 0, 0, "rh_idle");
      step(1, T_FPU, 1, 2, 12, 0, 0, "rh_fpu");
      step(1, T_ADDI, 0, 0, 13, 0, 0, "rh_hold");
      chk("rh_busy_before", {20'd0, out0[0]}, 21'd1);
      #2 rstn = 0;
      #1;
      chk("rst_mid_hold/lat4", out0, '0);
      chk("rst_mid_hold/lat1", out1, '0);
      model_reset(0);
      model_reset(1);
      @(negedge clk);
      rstn = 1; valid_id = 0; ext_stall = 0; branch_taken_ex = 0;
      step(0, T_NOP, 0, 0, 0, 0, 0, "post_rst");
      chk("busy_after_rst", {20'd0, out0[0]}, 21'd0);

      for (int i = 0; i < 600; i++) begin
         int idx = $urandom_range(0, 8);
         bit [6:0] op = (idx < 7) ? ref_op[idx] : 7'($urandom);
         step($urandom_range(0, 9) < 8, op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
